// File: rtl/bcd_binary_converter.sv
// bcd_binary_converter: sequential packed-BCD to binary converter using the
// reverse double-dabble algorithm. Each SHIFT cycle shifts the working
// register right by one and subtracts 3 from every BCD digit that is >= 8,
// producing one result bit per clock. Start/busy/done handshake.
//
// Optional build macro BCD_INPUT_CHECK_EN: when defined, an input with any
// digit > 9 is rejected on the accepting edge (bin=0, err=1, done in the
// next cycle). When undefined, err is always 0 and every input is converted.
module bcd_binary_converter #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SR_W-1:0]   r_sr, w_sr_nxt, w_sr_shr, w_sr_corr;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BIN_W-1:0]  r_bin, w_bin_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_bad;

  assign w_sr_shr = r_sr >> 1;

  // Digit correction on the shifted value: each BCD field >= 8 loses 3.
  always_comb begin
    w_sr_corr = w_sr_shr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_sr_shr[BIN_W + 4*i +: 4] >= 4'd8)
        w_sr_corr[BIN_W + 4*i +: 4] = w_sr_shr[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  // Flag any input digit above 9 so the conversion can be rejected at accept.
  always_comb begin
    w_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9)
        w_bad = 1'b1;
    end
  end
`else
  assign w_bad = 1'b0;
`endif

  // Next-state and next-register values for the conversion FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad) begin
            w_bin_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sr_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_sr_nxt    = {bcd, {BIN_W{1'b0}}};
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_sr_nxt  = w_sr_corr;
        w_cnt_nxt = r_cnt + 1'b1;
        // Final shift: the result is taken from the corrected value so bin
        // is updated on the same edge as the last shift.
        if (r_cnt == LAST_CNT) begin
          w_bin_nxt   = w_sr_corr[BIN_W-1:0];
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_sr   <= w_sr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_bin  <= w_bin_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign bin  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_binary_converter.sv
// Testbench for bcd_binary_converter: default 3-digit instance plus a
// 4-digit / 14-bit instance. Expected values come from decimal arithmetic
// on the BCD digits.
module tb_bcd_binary_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy, done, err;

  logic        start2;
  logic [15:0] bcd2;
  logic [13:0] bin2;
  logic        busy2, done2, err2;

  int total = 0;
  int bad   = 0;

  bcd_binary_converter #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
    .bin(bin), .busy(busy), .done(done), .err(err)
  );

  bcd_binary_converter #(.DIGITS(4), .BIN_W(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bcd(bcd2),
    .bin(bin2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd_value(input logic [15:0] b, input int nd);
    int v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] rand_bcd(input int nd);
    logic [15:0] b = '0;
    for (int i = 0; i < nd; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // One conversion on the 3-digit instance. lat = number of edges after the
  // accepting edge before done is seen (0 = done in the cycle right after it).
  task automatic run1(input string tag, input logic [11:0] b, input int exp_bin,
                      input int exp_lat, input bit exp_err, input bit chk_bin);
    logic [9:0] prev;
    int n;
    bit seen, stable, busy_ok;
    @(negedge clk);
    bcd = b; start = 1'b1; prev = bin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcd = 12'($urandom);
    n = 0; seen = 0; stable = 1; busy_ok = 1;
    while (n <= 40 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (bin !== prev) stable = 0;
        if (busy !== 1'b1) busy_ok = 0;
        @(negedge clk);
        n++;
      end
    end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".hold"}, 32'(stable), 32'd1);
    if (exp_lat > 0) check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    if (chk_bin) check({tag, ".bin"}, 32'(bin), 32'(exp_bin));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, cnt, first, second;
    logic [9:0] lastbin;
    logic [15:0] r;
    start = 0; bcd = '0; start2 = 0; bcd2 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst.bin",  32'(bin),  32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err",  32'(err),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run1("c999", 12'h999, 999, 10, 0, 1);
    run1("c000", 12'h000, 0,   10, 0, 1);
    run1("c001", 12'h001, 1,   10, 0, 1);
    run1("c100", 12'h100, 100, 10, 0, 1);
    run1("c255", 12'h255, 255, 10, 0, 1);
    run1("c512", 12'h512, 512, 10, 0, 1);
    for (int k = 0; k < 8; k++) begin
      r = rand_bcd(3);
      run1("rnd", r[11:0], bcd_value(r, 3), 10, 0, 1);
    end

    // start re-pulsed during a conversion is ignored
    @(negedge clk);
    bcd = 12'h123; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0; first = -1; lastbin = '0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) begin cnt++; lastbin = bin; if (first < 0) first = i; end
      start = (i == 3 || i == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check("repulse.count", 32'(cnt), 32'd1);
    check("repulse.lat",   32'(first), 32'd10);
    check("repulse.bin",   32'(lastbin), 32'd123);

    // start held high: back-to-back conversions every BIN_W+2 edges
    @(negedge clk);
    bcd = 12'h042; start = 1'b1;
    cnt = 0; first = -1; second = -1; lastbin = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cnt++; lastbin = bin;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    start = 1'b0;
    check("held.count", 32'(cnt), 32'd2);
    check("held.first", 32'(first), 32'd10);
    check("held.gap",   32'(second - first), 32'd12);
    check("held.bin",   32'(lastbin), 32'd42);
    repeat (16) @(negedge clk);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    bcd = 12'h987; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.bin",  32'(bin),  32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0; n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
      if (busy === 1'b1) n++;
    end
    check("mrst.nodone", 32'(cnt), 32'd0);
    check("mrst.nobusy", 32'(n), 32'd0);

    // invalid digit handling
`ifdef BCD_INPUT_CHECK_EN
    run1("inv", 12'h1A3, 0, 0, 1, 1);
    run1("after_inv", 12'h007, 7, 10, 0, 1);
`else
    run1("inv", 12'h1A3, 0, 10, 0, 0);
    run1("after_inv", 12'h007, 7, 10, 0, 1);
`endif

    // 4-digit / 14-bit instance
    for (int k = 0; k < 4; k++) begin
      r = (k == 0) ? 16'h9999 : rand_bcd(4);
      @(negedge clk);
      bcd2 = r; start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0; bcd2 = 16'($urandom);
      n = 0;
      while (n <= 40 && done2 !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      check("w14.lat", 32'(n), 32'd14);
      check("w14.bin", 32'(bin2), 32'(bcd_value(r, 4)));
      check("w14.err", 32'(err2), 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
